arqui_checker: RTL and testbench
================================

Name: arqui_checker

Overview:
Self-checking comparator for the arqui block's verification bench. It compares, cycle by cycle, the five output channels of the behavioural (conductual, suffix _c) model against the synthesized structural (estructural, suffix _e) netlist. It produces a registered pass flag plus sticky and diagnostic status. It sits beside the stimulus generator and observes only; it drives nothing back into the design.

Parameters:
DATA_SIZE, 6, width of data channels 0 and 1
CNT_W, 16, width of the mismatch counter

Ports:
clk  in  1  single clock; all state updates on rising edge
reset_L  in  1  synchronous reset, active-high (reset when reset_L==1 at posedge clk)
salida_arqui0_c  in  DATA_SIZE  channel 0 data (data_out0), behavioural
salida_arqui0_e  in  DATA_SIZE  channel 0 data, structural
salida_arqui1_c  in  DATA_SIZE  channel 1 data (data_out1), behavioural
salida_arqui1_e  in  DATA_SIZE  channel 1 data, structural
salida_arqui2_c  in  1  channel 2: error flag, behavioural
salida_arqui2_e  in  1  channel 2: error flag, structural
salida_arqui3_c  in  1  channel 3: active flag, behavioural
salida_arqui3_e  in  1  channel 3: active flag, structural
salida_arqui4_c  in  1  channel 4: idle flag, behavioural
salida_arqui4_e  in  1  channel 4: idle flag, structural
arqui_checks_out  out  1  1 = all five channels matched on the previous sampled edge
mismatch_mask  out  5  bit i = channel i mismatched on the previous sampled edge
error_sticky  out  1  set on the first mismatch, held until reset
mismatch_count  out  CNT_W  number of cycles with at least one mismatch, saturating

Behaviour:
- Reset (reset_L==1 at posedge clk): arqui_checks_out=1, mismatch_mask=0, error_sticky=0, mismatch_count=0.
  - Inputs are ignored while reset is held.
  - Reset mid-operation clears all state on that edge.
- Compare (combinational): match[i] = (salida_arquiI_c == salida_arquiI_e), full-width bitwise equality.
  - An X or Z on either side counts as a mismatch (match[i]=0).
- Update on each posedge clk when not in reset:
  - arqui_checks_out <= &match
  - mismatch_mask <= ~match
  - if any bit of match is 0: error_sticky <= 1, and mismatch_count <= mismatch_count+1, saturating at all-ones.
- Latency: exactly one clock from sampled inputs to every output. No pipelining beyond that.
- Simultaneous mismatches on several channels in one cycle: every affected bit is set in mismatch_mask; the counter increments by 1 only.
- error_sticky is never cleared except by reset, even if later cycles match.
- No handshake. The checker samples on every edge regardless of traffic.

Decomposition:
- Shared package arqui_chk_pkg:
  - NUM_CH=5
  - channel index constants CH_DATA0=0, CH_DATA1=1, CH_ERROR=2, CH_ACTIVE=3, CH_IDLE=4
  - default DATA_SIZE
- One sub-module, arqui_pair_cmp:
  - parameter W
  - inputs a[W-1:0], b[W-1:0]; output eq
  - X/Z-aware equality
  - instantiated once per channel: W=DATA_SIZE for channels 0–1, W=1 for channels 2–4.

Test Plan:
1. Hold reset_L=1 for 2 cycles with differing inputs (0x0F vs 0x00) -> arqui_checks_out=1, mismatch_mask=0, error_sticky=0, mismatch_count=0.
2. Release reset; drive identical values on all pairs (ch0=0x0E, ch1=0x05, flags 1/0/1) for 10 cycles -> arqui_checks_out=1 each cycle, count stays 0.
3. Single-cycle mismatch salida_arqui0_c=0x0D vs _e=0x0C -> next cycle arqui_checks_out=0, mismatch_mask=5'b00001, error_sticky=1, count=1.
   - Cycle after that, with inputs matching again: arqui_checks_out=1, mask=0, error_sticky stays 1.
4. Same-cycle mismatch on ch1, ch3 and ch4 -> mask=5'b11010, count increments by exactly 1.
5. Force salida_arqui2_e=X while _c=0 -> mismatch_mask[2]=1, arqui_checks_out=0.
6. With CNT_W=4, hold a mismatch for 20 cycles -> count saturates at 15. Assert reset_L=1 mid-run -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/arqui_chk_pkg.sv
// Shared constants for the arqui behavioural-vs-structural output checker.
// Channel indices double as bit positions in the mismatch mask.
package arqui_chk_pkg;

    localparam int NUM_CH            = 5;
    localparam int NUM_DATA_CH       = 2;
    localparam int CH_DATA0          = 0;
    localparam int CH_DATA1          = 1;
    localparam int CH_ERROR          = 2;
    localparam int CH_ACTIVE         = 3;
    localparam int CH_IDLE           = 4;
    localparam int DEFAULT_DATA_SIZE = 6;

    typedef logic [NUM_CH-1:0] ch_mask_t;

endpackage

// File: rtl/arqui_pair_cmp.sv
// Equality of one behavioural/structural channel pair.
// Any unknown bit on either side is reported as a mismatch.
module arqui_pair_cmp #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);

    // An X/Z in either operand propagates into the XOR, so the case-equality
    // against zero fails; hardware sees this as a plain zero-reduction.
    assign eq = ((a ^ b) === '0);

endmodule

// File: rtl/arqui_checker.sv
// Cycle-by-cycle comparator of the arqui behavioural model against its netlist.
// Registered pass flag, per-channel mismatch mask, sticky error and saturating count.
module arqui_checker
    import arqui_chk_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [DATA_SIZE-1:0] salida_arqui0_c,
    input  logic [DATA_SIZE-1:0] salida_arqui0_e,
    input  logic [DATA_SIZE-1:0] salida_arqui1_c,
    input  logic [DATA_SIZE-1:0] salida_arqui1_e,
    input  logic                 salida_arqui2_c,
    input  logic                 salida_arqui2_e,
    input  logic                 salida_arqui3_c,
    input  logic                 salida_arqui3_e,
    input  logic                 salida_arqui4_c,
    input  logic                 salida_arqui4_e,
    output logic                 arqui_checks_out,
    output logic [NUM_CH-1:0]    mismatch_mask,
    output logic                 error_sticky,
    output logic [CNT_W-1:0]     mismatch_count
);

    logic [DATA_SIZE-1:0] data_c [NUM_DATA_CH];
    logic [DATA_SIZE-1:0] data_e [NUM_DATA_CH];
    logic [NUM_CH-1:0]    flag_c;
    logic [NUM_CH-1:0]    flag_e;
    ch_mask_t             match;

    assign data_c[CH_DATA0] = salida_arqui0_c;
    assign data_e[CH_DATA0] = salida_arqui0_e;
    assign data_c[CH_DATA1] = salida_arqui1_c;
    assign data_e[CH_DATA1] = salida_arqui1_e;

    // Flag vectors are indexed by channel number; the data-channel slots are unused.
    assign flag_c = {salida_arqui4_c, salida_arqui3_c, salida_arqui2_c, 2'b00};
    assign flag_e = {salida_arqui4_e, salida_arqui3_e, salida_arqui2_e, 2'b00};

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            if (gi < NUM_DATA_CH) begin : g_data
                arqui_pair_cmp #(.W(DATA_SIZE)) u_cmp (
                    .a  (data_c[gi]),
                    .b  (data_e[gi]),
                    .eq (match[gi])
                );
            end else begin : g_flag
                arqui_pair_cmp #(.W(1)) u_cmp (
                    .a  (flag_c[gi]),
                    .b  (flag_e[gi]),
                    .eq (match[gi])
                );
            end
        end
    endgenerate

    logic             checks_reg;
    ch_mask_t         mask_reg;
    logic             sticky_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset_L) begin
            checks_reg <= 1'b1;
            mask_reg   <= '0;
            sticky_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            checks_reg <= &match;
            mask_reg   <= ~match;
            if (!(&match)) begin
                sticky_reg <= 1'b1;
                // Several channels failing together still count as one bad cycle.
                if (count_reg != '1) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end
    end

    assign arqui_checks_out = checks_reg;
    assign mismatch_mask    = mask_reg;
    assign error_sticky     = sticky_reg;
    assign mismatch_count   = count_reg;

endmodule

// File: tb/tb_arqui_checker.sv
// Directed bench for arqui_checker: a wide-counter instance and a 4-bit-counter
// instance observe the same stimulus; every step has hand-computed expectations.
module tb_arqui_checker;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [5:0] c0, e0, c1, e1;
    logic       c2, e2, c3, e3, c4, e4;

    logic        out_a, sticky_a;
    logic [4:0]  mask_a;
    logic [15:0] count_a;
    logic        out_b, sticky_b;
    logic [4:0]  mask_b;
    logic [3:0]  count_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arqui_checker #(.DATA_SIZE(6), .CNT_W(16)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .salida_arqui0_c  (c0),
        .salida_arqui0_e  (e0),
        .salida_arqui1_c  (c1),
        .salida_arqui1_e  (e1),
        .salida_arqui2_c  (c2),
        .salida_arqui2_e  (e2),
        .salida_arqui3_c  (c3),
        .salida_arqui3_e  (e3),
        .salida_arqui4_c  (c4),
        .salida_arqui4_e  (e4),
        .arqui_checks_out (out_a),
        .mismatch_mask    (mask_a),
        .error_sticky     (sticky_a),
        .mismatch_count   (count_a)
    );

    arqui_checker #(.DATA_SIZE(6), .CNT_W(4)) dut4 (
        .clk              (clk),
        .reset_L          (reset_L),
        .salida_arqui0_c  (c0),
        .salida_arqui0_e  (e0),
        .salida_arqui1_c  (c1),
        .salida_arqui1_e  (e1),
        .salida_arqui2_c  (c2),
        .salida_arqui2_e  (e2),
        .salida_arqui3_c  (c3),
        .salida_arqui3_e  (e3),
        .salida_arqui4_c  (c4),
        .salida_arqui4_e  (e4),
        .arqui_checks_out (out_b),
        .mismatch_mask    (mask_b),
        .error_sticky     (sticky_b),
        .mismatch_count   (count_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive_match();
        c0 = 6'h0E; e0 = 6'h0E;
        c1 = 6'h05; e1 = 6'h05;
        c2 = 1'b1;  e2 = 1'b1;
        c3 = 1'b0;  e3 = 1'b0;
        c4 = 1'b1;  e4 = 1'b1;
    endtask

    initial begin
        // 1: reset held with differing inputs
        reset_L = 1'b1;
        c0 = 6'h0F; e0 = 6'h00;
        c1 = 6'h0F; e1 = 6'h00;
        c2 = 1'b1;  e2 = 1'b0;
        c3 = 1'b1;  e3 = 1'b0;
        c4 = 1'b1;  e4 = 1'b0;
        tick();
        tick();
        check("rst_out", 32'(out_a), 32'd1);
        check("rst_mask", 32'(mask_a), 32'd0);
        check("rst_sticky", 32'(sticky_a), 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_count4", 32'(count_b), 32'd0);

        // 2: matching traffic
        reset_L = 1'b0;
        drive_match();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("match_out", 32'(out_a), 32'd1);
            check("match_count", 32'(count_a), 32'd0);
        end
        check("match_sticky", 32'(sticky_a), 32'd0);

        // 3: single-cycle mismatch on channel 0
        c0 = 6'h0D; e0 = 6'h0C;
        tick();
        check("ch0_out", 32'(out_a), 32'd0);
        check("ch0_mask", 32'(mask_a), 32'h01);
        check("ch0_sticky", 32'(sticky_a), 32'd1);
        check("ch0_count", 32'(count_a), 32'd1);
        drive_match();
        tick();
        check("rec_out", 32'(out_a), 32'd1);
        check("rec_mask", 32'(mask_a), 32'd0);
        check("rec_sticky", 32'(sticky_a), 32'd1);
        check("rec_count", 32'(count_a), 32'd1);

        // 4: simultaneous mismatch on channels 1, 3, 4
        e1 = 6'h06; e3 = 1'b1; e4 = 1'b0;
        tick();
        check("multi_mask", 32'(mask_a), 32'h1A);
        check("multi_count", 32'(count_a), 32'd2);
        check("multi_out", 32'(out_a), 32'd0);
        drive_match();
        tick();
        check("multi_rec", 32'(out_a), 32'd1);

        // 5: unknown on the structural error flag; a simulator without X
        // support gets a plain differing value instead
        c2 = 1'b0; e2 = 1'bx;
        if (!$isunknown(e2)) e2 = 1'b1;
        tick();
        check("x_mask", 32'(mask_a), 32'h04);
        check("x_out", 32'(out_a), 32'd0);
        check("x_count", 32'(count_a), 32'd3);
        drive_match();

        // 6: sustained mismatch saturates the narrow counter, then reset mid-run
        e0 = 6'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("sat_count4", 32'(count_b), 32'd15);
        check("sat_count16", 32'(count_a), 32'd23);
        check("sat_sticky4", 32'(sticky_b), 32'd1);
        reset_L = 1'b1;
        tick();
        check("mid_out", 32'(out_a), 32'd1);
        check("mid_mask", 32'(mask_a), 32'd0);
        check("mid_sticky", 32'(sticky_a), 32'd0);
        check("mid_count", 32'(count_a), 32'd0);
        check("mid_count4", 32'(count_b), 32'd0);
        check("mid_out4", 32'(out_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
